// File: rtl/cpu_run_controller_if.sv
// Host-side control and status bundle of the CPU run controller.
interface cpu_run_controller_if #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 step_mode;
  logic                 step_req;
  logic                 bp_en;
  logic [PC_WIDTH-1:0]  bp_addr;
  logic [PC_WIDTH-1:0]  pc_next;
  logic                 cpu_reset;
  logic                 cpu_clk_en;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic                 halted;
  logic [1:0]           halt_cause;
  logic                 busy;

  modport master (
    output start, step_mode, step_req, bp_en, bp_addr, pc_next,
    input  cpu_reset, cpu_clk_en, cycle_count, halted, halt_cause, busy
  );
  modport slave (
    input  start, step_mode, step_req, bp_en, bp_addr, pc_next,
    output cpu_reset, cpu_clk_en, cycle_count, halted, halt_cause, busy
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer for a CPU under test: holds it in reset, gates its
// clock, counts executed cycles and halts on self-loop, breakpoint or timeout.
module cpu_run_controller #(
  parameter int PC_WIDTH    = 8,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 500,
  parameter int STALL_LIMIT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  cpu_run_controller_if.slave bus
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, RESET_CPU, RUN, STEP_WAIT, STEP_EXEC, HALT} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rst_cnt;
  logic [SW-1:0]         stall_cnt, stall_nxt;
  logic [PC_WIDTH-1:0]   prev_pc;
  logic                  prev_vld;
  logic [1:0]            step_sync;
  logic                  step_edge, exec, hit_bp, hit_loop, hit_tmo;
  logic [1:0]            cause_d, cause_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign exec      = (state_q == RUN) || (state_q == STEP_EXEC);
  assign step_edge = step_sync[0] & ~step_sync[1];
  assign stall_nxt = (prev_vld && bus.pc_next == prev_pc) ? stall_cnt + 1'b1 : '0;
  assign hit_bp    = bus.bp_en && (bus.pc_next == bus.bp_addr);
  assign hit_loop  = (stall_nxt == SW'(STALL_LIMIT));
  assign hit_tmo   = (cnt_q == CNT_WIDTH'(MAX_CYCLES - 1));

  assign bus.cycle_count = cnt_q;
  assign bus.halt_cause  = cause_q;

  always_comb begin
    state_d = state_q;
    cause_d = 2'b00;
    if (exec) begin
      if (hit_bp)        cause_d = 2'b10;
      else if (hit_loop) cause_d = 2'b01;
      else if (hit_tmo)  cause_d = 2'b11;
    end
    case (state_q)
      IDLE, HALT: if (bus.start) state_d = RESET_CPU;
      RESET_CPU:  if (rst_cnt == RW'(RST_CYCLES - 1))
                    state_d = bus.step_mode ? STEP_WAIT : RUN;
      RUN: begin
        if (cause_d != 2'b00)   state_d = HALT;
        else if (bus.step_mode) state_d = STEP_WAIT;
      end
      // a step request beats a simultaneous switch back to free run
      STEP_WAIT: begin
        if (step_edge)           state_d = STEP_EXEC;
        else if (!bus.step_mode) state_d = RUN;
      end
      STEP_EXEC: state_d = (cause_d != 2'b00) ? HALT : STEP_WAIT;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      rst_cnt        <= '0;
      stall_cnt      <= '0;
      prev_pc        <= '0;
      prev_vld       <= 1'b0;
      step_sync      <= 2'b00;
      cnt_q          <= '0;
      cause_q        <= 2'b00;
      bus.cpu_reset  <= 1'b1;
      bus.cpu_clk_en <= 1'b0;
      bus.halted     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_sync <= {step_sync[0], bus.step_req};
      if (state_d == RESET_CPU && state_q != RESET_CPU) begin
        rst_cnt   <= '0;
        cnt_q     <= '0;
        stall_cnt <= '0;
        prev_vld  <= 1'b0;
        cause_q   <= 2'b00;
      end else begin
        if (state_q == RESET_CPU) rst_cnt <= rst_cnt + 1'b1;
        if (exec) begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          stall_cnt <= stall_nxt;
          prev_pc   <= bus.pc_next;
          prev_vld  <= 1'b1;
          if (cause_d != 2'b00) cause_q <= cause_d;
        end
      end
      // outputs follow the state being entered so they line up with state_q
      bus.cpu_reset  <= (state_d == IDLE) || (state_d == RESET_CPU);
      bus.cpu_clk_en <= (state_d == RESET_CPU) || (state_d == RUN) || (state_d == STEP_EXEC);
      bus.halted     <= (state_d == HALT);
      bus.busy       <= (state_d == RESET_CPU) || (state_d == RUN) ||
                        (state_d == STEP_WAIT) || (state_d == STEP_EXEC);
    end
  end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized bench: per-run halt outcome predicted from the PC trace it feeds.
module tb_cpu_run_controller;
  localparam int STALL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] pcs [0:1023];
  int   exec_total = 0;
  int   exec_base  = 0;

  cpu_run_controller_if #(.PC_WIDTH(8), .CNT_WIDTH(16)) a ();
  cpu_run_controller_if #(.PC_WIDTH(8), .CNT_WIDTH(16)) b ();

  cpu_run_controller dut (.CLOCK_50(clk), .reset(reset), .bus(a));
  cpu_run_controller #(.MAX_CYCLES(3)) dut3 (.CLOCK_50(clk), .reset(reset), .bus(b));

  assign b.start     = a.start;
  assign b.step_mode = a.step_mode;
  assign b.step_req  = a.step_req;
  assign b.bp_en     = a.bp_en;
  assign b.bp_addr   = a.bp_addr;
  assign b.pc_next   = a.pc_next;

  always #5 clk = ~clk;

  // Feed the next trace entry whenever the CPU is executing this cycle.
  always @(posedge clk) begin
    #1;
    if (a.cpu_clk_en === 1'b1 && a.cpu_reset === 1'b0) begin
      a.pc_next = pcs[(exec_total - exec_base) & 1023];
      exec_total++;
    end else begin
      a.pc_next = 8'h00;
    end
  end

  // Expected halt point from the trace: first executed cycle that trips a rule.
  function automatic void model(input int maxc, input bit be, input logic [7:0] ba,
                                output int cnt, output logic [1:0] cause);
    int run;
    run = 0; cnt = maxc; cause = 2'b11;
    for (int k = 0; k < maxc; k++) begin
      if (k > 0 && pcs[k] == pcs[k-1]) run++; else run = 0;
      if (be && pcs[k] == ba) begin cnt = k + 1; cause = 2'b10; return; end
      if (run == STALL)       begin cnt = k + 1; cause = 2'b01; return; end
    end
  endfunction

  task automatic do_start(input bit mode);
    @(negedge clk);
    a.start = 1'b1; a.step_mode = mode; exec_base = exec_total;
    @(negedge clk);
    a.start = 1'b0;
  endtask

  task automatic wait_halt(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (a.halted === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a.cpu_reset, a.cpu_clk_en, a.halted, a.busy, a.halt_cause} !== 6'b100000 ||
        a.cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rst/en/halt/busy/cause=%b count=%0d want 100000 count=0",
               {a.cpu_reset, a.cpu_clk_en, a.halted, a.busy, a.halt_cause}, a.cycle_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a.cpu_reset !== 1'b1 || a.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: cpu_reset=%b busy=%b want 1 0", a.cpu_reset, a.busy);
    end
  endtask

  task automatic test_timeout;
    int rc;
    bit ok, en_bad;
    logic [7:0] base;
    base = 8'($urandom);
    for (int k = 0; k < 1024; k++) pcs[k] = base + 8'(k);
    a.bp_en = 1'b0;
    do_start(1'b0);
    rc = 0; en_bad = 1'b0;
    while (a.cpu_reset === 1'b1 && rc < 20) begin
      if (a.cpu_clk_en !== 1'b1) en_bad = 1'b1;
      rc++;
      @(negedge clk);
    end
    checks++;
    if (rc !== 4 || en_bad) begin
      errors++;
      $display("FAIL reset_phase: cycles=%0d en_bad=%b want 4 0", rc, en_bad);
    end
    wait_halt(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_halt: halted=%b want 1", a.halted); end
    checks++;
    if (a.cycle_count !== 16'd500 || a.halt_cause !== 2'b11) begin
      errors++;
      $display("FAIL timeout_result: count=%0d cause=%b want 500 11", a.cycle_count, a.halt_cause);
    end
    checks++;
    if (exec_total - exec_base !== 500) begin
      errors++;
      $display("FAIL timeout_enables: got %0d want 500", exec_total - exec_base);
    end
  endtask

  task automatic test_self_loop;
    int ecnt, en_seen;
    logic [1:0] ecause;
    logic [7:0] base;
    bit ok;
    base = 8'($urandom);
    if (base == 8'hFD) base = 8'h00;
    for (int k = 0; k < 1024; k++) pcs[k] = (k < 20) ? base + 8'(k) : 8'h10;
    model(500, 1'b0, 8'h00, ecnt, ecause);
    a.bp_en = 1'b0;
    do_start(1'b0);
    checks++;
    if (a.cycle_count !== 16'd0 || a.halt_cause !== 2'b00 || a.halted !== 1'b0 || a.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: count=%0d cause=%b halted=%b busy=%b want 0 00 0 1",
               a.cycle_count, a.halt_cause, a.halted, a.busy);
    end
    wait_halt(2000, ok);
    checks++;
    if (!ok || a.cycle_count !== 16'(ecnt) || a.halt_cause !== ecause) begin
      errors++;
      $display("FAIL self_loop: ok=%b count=%0d cause=%b want 1 %0d %b",
               ok, a.cycle_count, a.halt_cause, ecnt, ecause);
    end
    en_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (a.cpu_clk_en !== 1'b0) en_seen++;
    end
    checks++;
    if (en_seen !== 0 || exec_total - exec_base !== ecnt) begin
      errors++;
      $display("FAIL halt_frozen: late_en=%0d execs=%0d want 0 %0d", en_seen, exec_total - exec_base, ecnt);
    end
  endtask

  task automatic test_breakpoint;
    bit ok;
    for (int k = 0; k < 1024; k++) pcs[k] = 8'(4 * k);
    a.bp_en = 1'b1; a.bp_addr = 8'h08;
    do_start(1'b0);
    wait_halt(100, ok);
    @(negedge clk);
    checks++;
    if (!ok || a.cycle_count !== 16'd3 || a.halt_cause !== 2'b10) begin
      errors++;
      $display("FAIL breakpoint: ok=%b count=%0d cause=%b want 1 3 10", ok, a.cycle_count, a.halt_cause);
    end
    checks++;
    if (b.halted !== 1'b1 || b.cycle_count !== 16'd3 || b.halt_cause !== 2'b10) begin
      errors++;
      $display("FAIL bp_over_timeout: halted=%b count=%0d cause=%b want 1 3 10",
               b.halted, b.cycle_count, b.halt_cause);
    end
  endtask

  task automatic test_random;
    int ecnt;
    logic [1:0] ecause;
    logic [7:0] ba;
    bit be, ok;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 1024; k++) pcs[k] = 8'($urandom_range(0, 3));
      be = 1'($urandom); ba = 8'($urandom_range(0, 3));
      model(500, be, ba, ecnt, ecause);
      a.bp_en = be; a.bp_addr = ba;
      do_start(1'b0);
      wait_halt(2000, ok);
      checks++;
      if (!ok || a.cycle_count !== 16'(ecnt) || a.halt_cause !== ecause ||
          exec_total - exec_base !== ecnt) begin
        errors++;
        $display("FAIL random_%0d: ok=%b count=%0d cause=%b execs=%0d want 1 %0d %b %0d",
                 it, ok, a.cycle_count, a.halt_cause, exec_total - exec_base, ecnt, ecause, ecnt);
      end
    end
  endtask

  task automatic test_step;
    logic [7:0] base;
    base = 8'($urandom);
    for (int k = 0; k < 1024; k++) pcs[k] = base + 8'(k);
    a.bp_en = 1'b0; a.step_req = 1'b0;
    do_start(1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (exec_total - exec_base !== 0 || a.cpu_clk_en !== 1'b0 || a.busy !== 1'b1) begin
      errors++;
      $display("FAIL step_idle: execs=%0d en=%b busy=%b want 0 0 1",
               exec_total - exec_base, a.cpu_clk_en, a.busy);
    end
    repeat (3) begin
      a.step_req = 1'b1; repeat (2) @(negedge clk);
      a.step_req = 1'b0; repeat (4) @(negedge clk);
    end
    a.step_req = 1'b1; repeat (10) @(negedge clk);
    a.step_req = 1'b0; repeat (6) @(negedge clk);
    checks++;
    if (exec_total - exec_base !== 4 || a.cycle_count !== 16'd4 || a.halted !== 1'b0) begin
      errors++;
      $display("FAIL single_step: execs=%0d count=%0d halted=%b want 4 4 0",
               exec_total - exec_base, a.cycle_count, a.halted);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    for (int k = 0; k < 1024; k++) pcs[k] = 8'(k);
    a.bp_en = 1'b0;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    do_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a.cycle_count === 16'd37) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reach_37: count=%0d want 37", a.cycle_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a.cycle_count !== 16'd0 || a.cpu_reset !== 1'b1 || a.cpu_clk_en !== 1'b0 ||
        a.busy !== 1'b0 || a.halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: count=%0d rst=%b en=%b busy=%b halted=%b want 0 1 0 0 0",
               a.cycle_count, a.cpu_reset, a.cpu_clk_en, a.busy, a.halted);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (a.cpu_clk_en !== 1'b0 || a.busy !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle: en=%b busy=%b want 0 0", a.cpu_clk_en, a.busy);
    end
  endtask

  initial begin
    a.start = 1'b0; a.step_mode = 1'b0; a.step_req = 1'b0;
    a.bp_en = 1'b0; a.bp_addr = 8'h00;
    test_reset;
    test_timeout;
    test_self_loop;
    test_breakpoint;
    test_random;
    test_step;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of the monitored CPU next-PC bus.
REQ-002 Parameter RST_CYCLES, default 4, number of cycles cpu_reset is held after start.
REQ-003 Parameter MAX_CYCLES, default 500, executed-cycle budget before timeout halt.
REQ-004 Parameter STALL_LIMIT, default 3, consecutive unchanged-PC cycles that count as a self-loop.
REQ-005 Parameter CNT_WIDTH, default 16, width of cycle_count.
REQ-006 CLOCK_50  in  1  system clock; single clock domain, all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high block reset.
REQ-008 start  in  1  level; sampled high in IDLE or HALT launches a run.
REQ-009 step_mode  in  1  1 = single-step operation, 0 = free run.
REQ-010 step_req  in  1  in step mode, each 0->1 transition executes one CPU cycle.
REQ-011 bp_en  in  1  breakpoint enable.
REQ-012 bp_addr  in  PC_WIDTH  breakpoint PC.
REQ-013 pc_next  in  PC_WIDTH  CPU next-PC, valid every cycle.
REQ-014 cpu_reset  out  1  reset driven to the CPU.
REQ-015 cpu_clk_en  out  1  CPU clock enable; CPU state advances only when 1.
REQ-016 cycle_count  out  CNT_WIDTH  executed CPU cycles since the last run start.
REQ-017 halted  out  1  high while in HALT.
REQ-018 halt_cause  out  2  00 none, 01 self-loop, 10 breakpoint, 11 timeout.
REQ-019 busy  out  1  high in RESET_CPU, RUN, STEP_WAIT, STEP_EXEC.

Function
REQ-020 FSM states SHALL be IDLE, RESET_CPU, RUN, STEP_WAIT, STEP_EXEC, HALT; all outputs registered.
REQ-021 IDLE: cpu_reset=1, cpu_clk_en=0; start=1 -> RESET_CPU next cycle.
REQ-022 RESET_CPU: cpu_reset=1, cpu_clk_en=1 for exactly RST_CYCLES cycles; cycle_count, stall counter, halt_cause cleared on entry; exit to RUN if step_mode=0, else STEP_WAIT.
REQ-023 RUN: cpu_reset=0, cpu_clk_en=1; step_mode=1 -> STEP_WAIT next cycle.
REQ-024 STEP_WAIT: cpu_clk_en=0; registered step_req rising edge -> STEP_EXEC; step_mode=0 -> RUN; rising edge wins if both occur in the same cycle.
REQ-025 STEP_EXEC: cpu_clk_en=1 for exactly one cycle, then STEP_WAIT; held-high step_req SHALL not produce further steps.
REQ-026 An executed cycle is any RUN or STEP_EXEC cycle; cycle_count SHALL increment by 1 per executed cycle and saturate at all-ones.
REQ-027 Self-loop: stall counter increments on an executed cycle with pc_next equal to pc_next of the previous executed cycle, else clears; reaching STALL_LIMIT -> HALT, cause 01.
REQ-028 Breakpoint: bp_en=1 and pc_next==bp_addr on an executed cycle -> HALT, cause 10.
REQ-029 Timeout: executed cycle on which cycle_count (pre-increment) equals MAX_CYCLES-1 -> HALT, cause 11.
REQ-030 Simultaneous halt conditions SHALL resolve breakpoint > self-loop > timeout; exactly one cause is recorded.
REQ-031 Halt takes effect the cycle after the triggering executed cycle: that cycle's count increment is kept, no further cycle is enabled.
REQ-032 HALT: cpu_reset=0, cpu_clk_en=0 (CPU state frozen for inspection), halted=1, halt_cause and cycle_count held; start=1 -> RESET_CPU.
REQ-033 start is ignored in all states other than IDLE and HALT.

Reset
REQ-034 reset=1 SHALL on the next edge force IDLE, cpu_reset=1, cpu_clk_en=0, cycle_count=0, halted=0, halt_cause=00, busy=0, clear stall counter and step_req edge register, regardless of current state.
REQ-035 reset has priority over start and every halt condition in the same cycle.

Verification
REQ-036 reset, start pulse, step_mode=0 -> cpu_reset high 4 cycles, then RUN; pc_next incrementing every cycle, bp_en=0 -> halt after 500 executed cycles, cycle_count=500, cause 11.
REQ-037 Free run, pc_next=0x10 held from executed cycle 20 on -> halted after stall counter hits 3, cause 01, cpu_clk_en=0 thereafter.
REQ-038 bp_en=1, bp_addr=0x08, pc_next stepping 0,4,8 -> halt with cause 10, cycle_count=3; same cycle also timeout-eligible (MAX_CYCLES=3) -> cause still 10.
REQ-039 step_mode=1, three step_req pulses plus one held high 10 cycles -> exactly 4 cpu_clk_en cycles after reset phase, cycle_count=4.
REQ-040 reset asserted mid-RUN at count 37 -> next cycle IDLE, count 0, cpu_reset=1; start from HALT restarts with count 0, cause 00.
